bcd_press_counter: RTL and testbench
====================================

// Module: bcd_press_counter
// PURPOSE
// - Downstream of the per-switch debounce stage. Consumes debounced, active-high switch levels and keeps a 2-digit BCD count (00-99).
// - One switch increments the count, one decrements it and one clears it. Holding inc or dec auto-repeats.
// - Drives the two active-low 7-segment digits directly: digit 1 shows tens, digit 2 shows ones.
// PARAMETERS
// - REPEAT_DELAY   12_500_000  cycles a key must stay held after its first step before auto-repeat starts (0.5 s at 25 MHz)
// - REPEAT_PERIOD  2_500_000   cycles between auto-repeat steps (100 ms at 25 MHz)
// - WRAP           1           1: wrap 99->00 and 00->99; 0: saturate at 99 and at 00
// PORTS
// - i_clk        in   1  system clock
// - i_rst_n      in   1  asynchronous, active-low reset
// - i_inc        in   1  debounced increment key, 1 = pressed
// - i_dec        in   1  debounced decrement key, 1 = pressed
// - i_clr        in   1  debounced clear key, 1 = pressed
// - o_count_bcd  out  8  {tens[3:0], ones[3:0]}, registered
// - o_step       out  1  one-cycle pulse when the count changes because of inc or dec (also pulses when a saturated step is refused)
// - o_seg_tens   out  7  {g,f,e,d,c,b,a} for digit 1, active-low (0 = segment lit)
// - o_seg_ones   out  7  {g,f,e,d,c,b,a} for digit 2, active-low
// BEHAVIOUR
// - Reset (asynchronous assert, synchronous release): count=8'h00, o_step=0, both seg outputs=7'b1000000 ("0"), FSM=IDLE, timer=0, key history regs=0.
// - Edge detection: registered copies r_inc/r_dec/r_clr. Rise = input 1 while its register is 0.
// - Step timing: a step sampled at edge N updates o_count_bcd at edge N. o_step is high for the cycle after edge N. Segments update at edge N+1 (1-cycle decode latency).
// - Clear: a rise of i_clr sets count to 00 and forces FSM to IDLE. Clear dominates any step in the same cycle. o_step stays 0.
// - Conflict: if i_inc and i_dec are both 1, no step occurs and the FSM goes to IDLE. The key that is still held afterwards needs a new rise to step.
// - FSM, states IDLE, DELAY, REPEAT; dir reg selects inc or dec:
//   - IDLE -> DELAY: on a rise of exactly one of inc/dec. Steps once, latches dir, timer=0.
//   - DELAY: timer++ while the dir key is held. When timer==REPEAT_DELAY-1: step, timer=0, go to REPEAT.
//   - REPEAT: timer++. When timer==REPEAT_PERIOD-1: step, timer=0.
//   - DELAY/REPEAT -> IDLE: on release of the dir key, or on the other key going high. Timer=0 and no step on that cycle.
// - Timer width is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)). It never exceeds its terminal value.
// - BCD increment: ones 9 -> 0 with tens+1. At 99: WRAP=1 gives 00, WRAP=0 holds 99.
// - BCD decrement: ones 0 -> 9 with tens-1. At 00: WRAP=1 gives 99, WRAP=0 holds 00.
// - A refused saturated step still pulses o_step. Ones and tens are never outside 0-9.
// - Decoder, active-low {g..a}: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
// - Reset asserted mid-hold: all state returns to reset values immediately. After release, a key still held needs a fresh rise to step.
// TESTING (bench params: REPEAT_DELAY=8, REPEAT_PERIOD=3)
// - Reset, then pulse i_inc high for 1 cycle -> count 01 and one o_step; next cycle o_seg_ones=1111001, o_seg_tens=1000000.
// - Hold i_inc 20 cycles from 00 -> steps at the press, +8, +11, +14, +17, +20 cycles; final count 06; release gives no further step.
// - Count 99, WRAP=1, inc tap -> 00. WRAP=0, inc tap -> stays 99 with o_step pulsing. Count 00, dec tap -> 99 (WRAP=1) or 00 (WRAP=0).
// - Count 19, dec tap -> 18. Count 10, dec tap -> 09 with o_seg_tens=1000000, o_seg_ones=0010000.
// - Count 42, i_clr rises in the same cycle as an i_inc rise -> 00, o_step=0. Hold i_inc and i_dec together -> no steps and the FSM stays IDLE.
// - Hold i_inc into REPEAT, pulse i_rst_n low for 1 cycle -> count 00 at once; with inc still held after reset -> no step until inc is released and pressed again.

Source files
------------

// File: rtl/bcd_press_counter.sv
// -----------------------------------------------------------------------------
// bcd_press_counter
//
// Two-digit BCD press counter (00-99) driven by debounced push-buttons.
// One key counts up, one counts down and one clears the count. Holding the
// up or down key steps once on the press, again after REPEAT_DELAY cycles,
// and then every REPEAT_PERIOD cycles until the key is released.
// The count drives two active-low 7-segment digits directly.
//
// Parameters
//   REPEAT_DELAY   cycles a key stays held after its first step before repeat
//   REPEAT_PERIOD  cycles between auto-repeat steps
//   WRAP           1: 99 -> 00 and 00 -> 99; 0: saturate at 99 and at 00
//
// Ports
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset (released synchronously here)
//   i_inc          debounced increment key, 1 = pressed
//   i_dec          debounced decrement key, 1 = pressed
//   i_clr          debounced clear key, 1 = pressed
//   o_count_bcd    {tens, ones}, registered
//   o_step         one-cycle pulse for every inc/dec step, refused ones too
//   o_seg_tens     {g,f,e,d,c,b,a} for the tens digit, 0 = segment lit
//   o_seg_ones     {g,f,e,d,c,b,a} for the ones digit, 0 = segment lit
// -----------------------------------------------------------------------------
module bcd_press_counter #(
    parameter int unsigned REPEAT_DELAY  = 12_500_000,
    parameter int unsigned REPEAT_PERIOD = 2_500_000,
    parameter bit          WRAP          = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_clr,
    output logic [7:0] o_count_bcd,
    output logic       o_step,
    output logic [6:0] o_seg_tens,
    output logic [6:0] o_seg_ones
);

    localparam int unsigned TIMER_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
    localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_t;

    // -------------------------------------------------------------------------
    // BCD helpers
    // -------------------------------------------------------------------------
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
        if (v[7:4] != 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return WRAP ? 8'h00 : 8'h99;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
        if (v[7:4] != 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return WRAP ? 8'h99 : 8'h00;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Reset synchroniser: assertion reaches all state at once, release is
    // aligned to i_clk so no flop sees it near an edge.
    // -------------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst_n;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // -------------------------------------------------------------------------
    // Key edge detection, bit order {clr, dec, inc}.
    // key_armed records that a key has been seen released since reset, so a
    // key held through reset must be released and pressed again to count.
    // -------------------------------------------------------------------------
    logic [2:0] keys;
    logic [2:0] key_q;
    logic [2:0] key_armed;
    logic [2:0] key_rise;
    logic       inc_rise;
    logic       dec_rise;
    logic       clr_rise;

    assign keys     = {i_clr, i_dec, i_inc};
    assign key_rise = keys & ~key_q & key_armed;
    assign inc_rise = key_rise[0];
    assign dec_rise = key_rise[1];
    assign clr_rise = key_rise[2];

    // -------------------------------------------------------------------------
    // Press / auto-repeat FSM
    // -------------------------------------------------------------------------
    state_t             state;
    state_t             state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic               dir_down;     // 0 = counting up, 1 = counting down
    logic               dir_nxt;
    logic               do_step;
    logic               dir_held;

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        dir_nxt   = dir_down;
        do_step   = 1'b0;
        dir_held  = dir_down ? i_dec : i_inc;

        if (clr_rise) begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
        end else if (i_inc && i_dec) begin
            // Both keys down is ambiguous: drop back and wait for a clean press.
            state_nxt = S_IDLE;
            timer_nxt = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (inc_rise || dec_rise) begin
                        state_nxt = S_DELAY;
                        timer_nxt = '0;
                        dir_nxt   = dec_rise;
                        do_step   = 1'b1;
                    end
                end
                S_DELAY: begin
                    if (!dir_held) begin
                        state_nxt = S_IDLE;
                        timer_nxt = '0;
                    end else if (timer == DELAY_LAST) begin
                        state_nxt = S_REPEAT;
                        timer_nxt = '0;
                        do_step   = 1'b1;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!dir_held) begin
                        state_nxt = S_IDLE;
                        timer_nxt = '0;
                    end else if (timer == PERIOD_LAST) begin
                        timer_nxt = '0;
                        do_step   = 1'b1;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State, count and display registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            dir_down    <= 1'b0;
            key_q       <= '0;
            key_armed   <= '0;
            o_count_bcd <= 8'h00;
            o_step      <= 1'b0;
            o_seg_tens  <= SEG_ZERO;
            o_seg_ones  <= SEG_ZERO;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            dir_down  <= dir_nxt;
            key_q     <= keys;
            key_armed <= key_armed | ~keys;
            o_step    <= do_step;

            if (clr_rise)
                o_count_bcd <= 8'h00;
            else if (do_step)
                o_count_bcd <= dir_nxt ? bcd_dec(o_count_bcd) : bcd_inc(o_count_bcd);

            // Display follows the count one cycle later.
            o_seg_tens <= seg_decode(o_count_bcd[7:4]);
            o_seg_ones <= seg_decode(o_count_bcd[3:0]);
        end
    end

endmodule

// File: tb/tb_bcd_press_counter.sv
module tb_bcd_press_counter;

    localparam int D = 8;
    localparam int P = 3;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG1 = 7'b1111001;
    localparam logic [6:0] SEG9 = 7'b0010000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic inc   = 1'b0;
    logic dec   = 1'b0;
    logic clr   = 1'b0;

    logic [7:0] w_cnt, s_cnt;
    logic       w_step, s_step;
    logic [6:0] w_st, w_so, s_st, s_so;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_press_counter #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P), .WRAP(1'b1)) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_inc(inc), .i_dec(dec), .i_clr(clr),
        .o_count_bcd(w_cnt), .o_step(w_step), .o_seg_tens(w_st), .o_seg_ones(w_so)
    );

    bcd_press_counter #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P), .WRAP(1'b0)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_inc(inc), .i_dec(dec), .i_clr(clr),
        .o_count_bcd(s_cnt), .o_step(s_step), .o_seg_tens(s_st), .o_seg_ones(s_so)
    );

    // -------------------------------------------------------------------------
    // Reference model: integer counts, and a hold length measured from the
    // stepping press. Steps fall at hold lengths 0, D, D+P, D+2P, ...
    // -------------------------------------------------------------------------
    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    int       m_w, m_s;              // wrapping and saturating counts, 0..99
    int       m_w_shown, m_s_shown;  // counts the displays currently show
    bit       m_step;
    int       m_mode;                // 0 idle, +1 holding inc, -1 holding dec
    int       m_held;                // edges the active key has been held past its press
    bit [2:0] m_prev, m_seen_low;    // {clr, dec, inc}
    int       m_rel;                 // clock edges since reset release
    bit [2:0] mk_keys, mk_rise;
    bit       mk_step;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_w = 0; m_s = 0; m_w_shown = 0; m_s_shown = 0; m_step = 0;
            m_mode = 0; m_held = 0; m_prev = '0; m_seen_low = '0; m_rel = 0;
        end else if (m_rel < 2) begin
            m_rel++;   // reset release takes two edges to reach the logic
        end else begin
            mk_keys    = {clr, dec, inc};
            mk_rise    = mk_keys & ~m_prev & m_seen_low;
            m_prev     = mk_keys;
            m_seen_low = m_seen_low | ~mk_keys;
            m_w_shown  = m_w;
            m_s_shown  = m_s;
            mk_step    = 1'b0;
            if (mk_rise[2]) begin
                m_w = 0; m_s = 0; m_mode = 0;
            end else if (inc && dec) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (mk_rise[0])      begin m_mode = 1;  m_held = 0; mk_step = 1'b1; end
                else if (mk_rise[1]) begin m_mode = -1; m_held = 0; mk_step = 1'b1; end
            end else if ((m_mode == 1 && !inc) || (m_mode == -1 && !dec)) begin
                m_mode = 0;
            end else begin
                m_held++;
                if (m_held == D || (m_held > D && (m_held - D) % P == 0)) mk_step = 1'b1;
            end
            if (mk_step) begin
                if (m_mode == 1) begin
                    m_w = (m_w + 1) % 100;
                    m_s = (m_s < 99) ? m_s + 1 : 99;
                end else begin
                    m_w = (m_w + 99) % 100;
                    m_s = (m_s > 0) ? m_s - 1 : 0;
                end
            end
            m_step = mk_step;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (all return on a falling edge)
    // -------------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
    endtask

    task automatic taps_inc(input int n);
        repeat (n) begin inc = 1'b1; cyc(1); inc = 1'b0; cyc(1); end
    endtask

    task automatic taps_dec(input int n);
        repeat (n) begin dec = 1'b1; cyc(1); dec = 1'b0; cyc(1); end
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if ({w_cnt, w_step, w_st, w_so} !== {8'h00, 1'b0, SEG0, SEG0}) begin
            failures++;
            $display("FAIL reset_wrap: got cnt=%h step=%b seg=%b/%b expected 00 0 %b/%b",
                     w_cnt, w_step, w_st, w_so, SEG0, SEG0);
        end
        checks++;
        if ({s_cnt, s_step, s_st, s_so} !== {8'h00, 1'b0, SEG0, SEG0}) begin
            failures++;
            $display("FAIL reset_sat: got cnt=%h step=%b seg=%b/%b expected 00 0 %b/%b",
                     s_cnt, s_step, s_st, s_so, SEG0, SEG0);
        end
    endtask

    task automatic test_single_inc();
        apply_reset();
        inc = 1'b1; cyc(1); inc = 1'b0;
        checks++;
        if (w_cnt !== 8'h01) begin failures++; $display("FAIL tap_count: got %h expected 01", w_cnt); end
        checks++;
        if (w_step !== 1'b1) begin failures++; $display("FAIL tap_step: got %b expected 1", w_step); end
        checks++;
        if (w_so !== SEG0) begin failures++; $display("FAIL tap_seg_latency: got %b expected %b", w_so, SEG0); end
        cyc(1);
        checks++;
        if (w_step !== 1'b0) begin failures++; $display("FAIL tap_step_width: got %b expected 0", w_step); end
        checks++;
        if ({w_st, w_so} !== {SEG0, SEG1}) begin
            failures++;
            $display("FAIL tap_seg: got %b/%b expected %b/%b", w_st, w_so, SEG0, SEG1);
        end
    endtask

    task automatic test_hold_repeat();
        int exp_pos [6] = '{0, 8, 11, 14, 17, 20};
        int got_pos [$];
        int late_steps = 0;
        apply_reset();
        // Held across 21 sampling edges: the press edge plus 20 more.
        inc = 1'b1;
        for (int k = 0; k < 21; k++) begin
            cyc(1);
            if (w_step === 1'b1) got_pos.push_back(k);
            checks++;
            if (w_cnt !== to_bcd(m_w)) begin
                failures++;
                $display("FAIL hold_count_k%0d: got %h expected %h", k, w_cnt, to_bcd(m_w));
            end
        end
        inc = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            if (w_step !== 1'b0) late_steps++;
        end
        checks++;
        if (got_pos.size() != 6) begin
            failures++;
            $display("FAIL hold_step_count: got %0d expected 6", got_pos.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_pos[i] != exp_pos[i]) begin
                    failures++;
                    $display("FAIL hold_step_pos%0d: got %0d expected %0d", i, got_pos[i], exp_pos[i]);
                end
            end
        end
        checks++;
        if (late_steps != 0) begin failures++; $display("FAIL hold_release_steps: got %0d expected 0", late_steps); end
        checks++;
        if (w_cnt !== 8'h06) begin failures++; $display("FAIL hold_final: got %h expected 06", w_cnt); end
    endtask

    task automatic test_wrap_saturate();
        apply_reset();
        dec = 1'b1; cyc(1); dec = 1'b0;
        checks++;
        if (w_cnt !== 8'h99) begin failures++; $display("FAIL dec_wrap: got %h expected 99", w_cnt); end
        checks++;
        if ({s_cnt, s_step} !== {8'h00, 1'b1}) begin
            failures++;
            $display("FAIL dec_sat: got cnt=%h step=%b expected 00 1", s_cnt, s_step);
        end
        cyc(1);
        checks++;
        if ({w_st, w_so} !== {SEG9, SEG9}) begin
            failures++;
            $display("FAIL dec_wrap_seg: got %b/%b expected %b/%b", w_st, w_so, SEG9, SEG9);
        end

        // Ride auto-repeat up to 99 on the saturating copy.
        apply_reset();
        inc = 1'b1;
        for (int k = 0; k < 400 && m_s != 99; k++) cyc(1);
        inc = 1'b0;
        cyc(2);
        checks++;
        if ({w_cnt, s_cnt} !== {8'h99, 8'h99}) begin
            failures++;
            $display("FAIL reach_99: got %h/%h expected 99/99", w_cnt, s_cnt);
        end
        inc = 1'b1; cyc(1); inc = 1'b0;
        checks++;
        if ({w_cnt, w_step} !== {8'h00, 1'b1}) begin
            failures++;
            $display("FAIL inc_wrap: got cnt=%h step=%b expected 00 1", w_cnt, w_step);
        end
        checks++;
        if ({s_cnt, s_step} !== {8'h99, 1'b1}) begin
            failures++;
            $display("FAIL inc_sat: got cnt=%h step=%b expected 99 1", s_cnt, s_step);
        end
    endtask

    task automatic test_dec_digits();
        apply_reset();
        taps_inc(19);
        dec = 1'b1; cyc(1); dec = 1'b0;
        checks++;
        if (w_cnt !== 8'h18) begin failures++; $display("FAIL dec_19: got %h expected 18", w_cnt); end
        cyc(1);
        taps_dec(8);
        dec = 1'b1; cyc(1); dec = 1'b0;
        checks++;
        if ({w_cnt, s_cnt} !== {8'h09, 8'h09}) begin
            failures++;
            $display("FAIL dec_10: got %h/%h expected 09/09", w_cnt, s_cnt);
        end
        cyc(1);
        checks++;
        if ({w_st, w_so} !== {SEG0, SEG9}) begin
            failures++;
            $display("FAIL dec_10_seg: got %b/%b expected %b/%b", w_st, w_so, SEG0, SEG9);
        end
    endtask

    task automatic test_clear_conflict();
        int steps = 0;
        apply_reset();
        taps_inc(42);
        checks++;
        if (w_cnt !== 8'h42) begin failures++; $display("FAIL setup_42: got %h expected 42", w_cnt); end
        clr = 1'b1; inc = 1'b1; cyc(1);
        checks++;
        if ({w_cnt, w_step} !== {8'h00, 1'b0}) begin
            failures++;
            $display("FAIL clr_over_inc: got cnt=%h step=%b expected 00 0", w_cnt, w_step);
        end
        clr = 1'b0; inc = 1'b0; cyc(2);
        taps_inc(3);
        inc = 1'b1; dec = 1'b1;
        for (int k = 0; k < 15; k++) begin cyc(1); if (w_step !== 1'b0) steps++; end
        inc = 1'b0;
        for (int k = 0; k < 6; k++) begin cyc(1); if (w_step !== 1'b0) steps++; end
        checks++;
        if (steps != 0) begin failures++; $display("FAIL both_keys_steps: got %0d expected 0", steps); end
        checks++;
        if (w_cnt !== 8'h03) begin failures++; $display("FAIL both_keys_count: got %h expected 03", w_cnt); end
        dec = 1'b0; cyc(1);
        inc = 1'b1; cyc(1); inc = 1'b0;
        checks++;
        if ({w_cnt, w_step} !== {8'h04, 1'b1}) begin
            failures++;
            $display("FAIL after_conflict: got cnt=%h step=%b expected 04 1", w_cnt, w_step);
        end
    endtask

    task automatic test_reset_mid_hold();
        int steps = 0;
        apply_reset();
        inc = 1'b1;
        cyc(14);
        checks++;
        if (w_cnt !== 8'h03) begin failures++; $display("FAIL mid_hold_setup: got %h expected 03", w_cnt); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({w_cnt, w_step, w_st, w_so} !== {8'h00, 1'b0, SEG0, SEG0}) begin
            failures++;
            $display("FAIL async_reset: got cnt=%h step=%b seg=%b/%b expected 00 0 %b/%b",
                     w_cnt, w_step, w_st, w_so, SEG0, SEG0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin cyc(1); if (w_step !== 1'b0) steps++; end
        checks++;
        if (steps != 0 || w_cnt !== 8'h00) begin
            failures++;
            $display("FAIL held_through_reset: got steps=%0d cnt=%h expected 0 00", steps, w_cnt);
        end
        inc = 1'b0; cyc(2);
        inc = 1'b1; cyc(1); inc = 1'b0;
        checks++;
        if ({w_cnt, w_step} !== {8'h01, 1'b1}) begin
            failures++;
            $display("FAIL fresh_press: got cnt=%h step=%b expected 01 1", w_cnt, w_step);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 700; k++) begin
            if ($urandom_range(0, 15) == 0) inc = ~inc;
            if ($urandom_range(0, 19) == 0) dec = ~dec;
            clr = ($urandom_range(0, 39) == 0);
            cyc(1);
            checks++;
            if ({w_cnt, w_step, w_st, w_so} !==
                {to_bcd(m_w), m_step, seg_tbl[m_w_shown / 10], seg_tbl[m_w_shown % 10]}) begin
                failures++;
                $display("FAIL rand_wrap_c%0d: got cnt=%h step=%b seg=%b/%b expected cnt=%h step=%b shown=%0d",
                         k, w_cnt, w_step, w_st, w_so, to_bcd(m_w), m_step, m_w_shown);
            end
            checks++;
            if ({s_cnt, s_step, s_st, s_so} !==
                {to_bcd(m_s), m_step, seg_tbl[m_s_shown / 10], seg_tbl[m_s_shown % 10]}) begin
                failures++;
                $display("FAIL rand_sat_c%0d: got cnt=%h step=%b seg=%b/%b expected cnt=%h step=%b shown=%0d",
                         k, s_cnt, s_step, s_st, s_so, to_bcd(m_s), m_step, m_s_shown);
            end
        end
        inc = 1'b0; dec = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_hold_repeat();
        test_wrap_saturate();
        test_dec_digits();
        test_clear_conflict();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
